// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Handshake and operand/result bundle for serial_subtractor.
//                The Ovf signal exists only when SUB_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef SUB_OVF_EN
    logic             Ovf;

    modport master (output start, A, B, Bin, input ready, done, Diff, Bout, Ovf);
    modport slave  (input start, A, B, Bin, output ready, done, Diff, Bout, Ovf);
`else
    modport master (output start, A, B, Bin, input ready, done, Diff, Bout);
    modport slave  (input start, A, B, Bin, output ready, done, Diff, Bout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor, Diff = A - B - Bin, one bit per clock,
//                LSB first, using a single full-subtractor cell. Optional
//                signed-overflow output enabled by macro SUB_OVF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ready_c;
    logic             done_c;

    // Full-subtractor cell working on the current LSBs of the operand shifters
    logic a_i;
    logic b_i;
    logic d_i;
    logic br_nxt;
    logic last_bit;
    logic accept;

    assign a_i      = a_sr[0];
    assign b_i      = b_sr[0];
    assign d_i      = a_i ^ b_i ^ br;
    assign br_nxt   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign accept   = (state == S_IDLE) && bus.start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> BUSY on accept, BUSY -> DONE after the MSB, DONE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_BUSY;
            S_BUSY:  if (last_bit)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        ready_c = 1'b0;
        done_c  = 1'b0;
        case (state)
            S_IDLE:  ready_c = 1'b1;
            S_DONE:  done_c  = 1'b1;
            default: begin
                ready_c = 1'b0;
                done_c  = 1'b0;
            end
        endcase
    end

    assign bus.ready = ready_c;
    assign bus.done  = done_c;
    assign bus.Diff  = diff_r;
    assign bus.Bout  = bout_r;

    // Datapath: load on accept, shift one bit per BUSY cycle, publish on the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            br     <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            a_sr <= bus.A;
            b_sr <= bus.B;
            br   <= bus.Bin;
            res  <= '0;
        end else if (state == S_BUSY) begin
            cnt  <= cnt + CNT_W'(1);
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            br   <= br_nxt;
            // New bit enters at the MSB so bit 0 ends up holding the first result bit
            res  <= {d_i, res[WIDTH-1:1]};
            if (last_bit) begin
                diff_r <= {d_i, res[WIDTH-1:1]};
                bout_r <= br_nxt;
            end
        end
    end

`ifdef SUB_OVF_EN
    logic ovf_r;

    // Overflow: borrow into the sign bit differs from borrow out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if ((state == S_BUSY) && last_bit) begin
            ovf_r <= br ^ br_nxt;
        end
    end

    assign bus.Ovf = ovf_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Scoreboard testbench for serial_subtractor (WIDTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   done_count;
    logic prev_done;
    exp_t sb[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        exp_t e;
        int   ua;
        int   ub;
        int   sa;
        int   sbv;
        int   sres;
        int   ures;
        ua   = int'(a);
        ub   = int'(b);
        sa   = (ua >= 8) ? ua - 16 : ua;
        sbv  = (ub >= 8) ? ub - 16 : ub;
        ures = ua - ub - int'(bin);
        sres = sa - sbv - int'(bin);
        e.diff = ures[WIDTH-1:0];
        e.bout = (ures < 0);
        e.ovf  = (sres > 7) || (sres < -8);
        return e;
    endfunction

    // Result monitor: every done pulse pops and compares one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            done_count++;
            if (prev_done) check_val("done_width", 32'd2, 32'd1);
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("diff", 32'(bus.Diff), 32'(e.diff));
                check_val("bout", 32'(bus.Bout), 32'(e.bout));
`ifdef SUB_OVF_EN
                check_val("ovf", 32'(bus.Ovf), 32'(e.ovf));
`endif
            end
        end
        prev_done = bus.done;
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one operation and wait for its done; checks accept and latency
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        int lat;
        wait_ready();
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        sb.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        check_val("ready_low", 32'(bus.ready), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = WIDTH'($urandom);
        bus.B     = WIDTH'($urandom);
        bus.Bin   = 1'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
        check_val("latency", 32'(lat), 32'(WIDTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        errors     = 0;
        checks     = 0;
        done_count = 0;
        prev_done  = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.Bin    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(bus.ready), 32'd1);
        check_val("rst_done",  32'(bus.done),  32'd0);
        check_val("rst_diff",  32'(bus.Diff),  32'd0);
        check_val("rst_bout",  32'(bus.Bout),  32'd0);
`ifdef SUB_OVF_EN
        check_val("rst_ovf",   32'(bus.Ovf),   32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(4'b0101, 4'b0011, 1'b0);
        run_op(4'b0011, 4'b0101, 1'b0);
        run_op(4'b0000, 4'b0000, 1'b1);
        run_op(4'b1000, 4'b0001, 1'b0);
        run_op(4'b1111, 4'b1111, 1'b1);

        // Starts during BUSY and DONE must be ignored
        wait_ready();
        base      = done_count;
        bus.A     = 4'b1111;
        bus.B     = 4'b0001;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        sb.push_back(model(4'b1111, 4'b0001, 1'b0));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.A     = 4'b0000;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("busy_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        bus.A     = 4'b0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check_val("done_ready", 32'(bus.ready), 32'd1);
        check_val("done_fall",  32'(bus.done),  32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val("busy_single_done", 32'(done_count - base), 32'd1);
        check_val("idle_hold", 32'(bus.Diff), 32'he);
        @(negedge clk);
        bus.A     = 4'b0101;
        bus.B     = 4'b0011;
        bus.start = 1'b1;
        sb.push_back(model(4'b0101, 4'b0011, 1'b0));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("busy_hold", 32'(bus.Diff), 32'he);
        repeat (4) @(posedge clk);

        // Asynchronous reset in the middle of an operation
        wait_ready();
        base      = done_count;
        bus.A     = 4'b1010;
        bus.B     = 4'b0100;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        sb.push_back(model(4'b1010, 4'b0100, 1'b0));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check_val("mid_rst_ready", 32'(bus.ready), 32'd1);
        check_val("mid_rst_done",  32'(bus.done),  32'd0);
        check_val("mid_rst_diff",  32'(bus.Diff),  32'd0);
        check_val("mid_rst_bout",  32'(bus.Bout),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val("no_done_after_rst", 32'(done_count - base), 32'd0);
        run_op(4'b0101, 4'b0011, 1'b0);

        // Random operations
        for (int i = 0; i < 20; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        repeat (4) @(posedge clk);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
